iht: RTL
========

# iht

Inverse of the three-level integer Haar (S-transform) produced by the forward `ht` pipeline. It accepts one `index`-element coefficient vector on `start` and reconstructs the original samples with an iterative single-butterfly engine, one coefficient pair per cycle. It then presents the result with a one-cycle `over` pulse. It sits on the decode side of the hackathon datapath, feeding reconstructed samples back to the testbench or downstream consumer.

## Interface
- `index`, 8: vector length; power of two, at least 2.
- `width`, 8: element width in bits; all arithmetic is modulo 2^width.
- `index_width`, 3: log2(`index`); this is also the number of levels.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset. It clears all state immediately.
- `start` input, 1 bit: request; sampled only in IDLE.
- `indata` input, [width-1:0] x [0:index-1]: coefficient vector, captured on the accepting edge.
- `outdata` output, [width-1:0] x [0:index-1]: work register; holds the reconstructed samples from `over` until the next accepted `start`.
- `busy` output, 1 bit: high from the accepting edge until the return to IDLE.
- `over` output, 1 bit: one-cycle done pulse.

## Operation
- Coefficient layout: position 0 is the top sum. At forward level L (group size n = index>>(L-1)), the sums sit at 0..n/2-1 and the differences at n/2..n-1.
- Butterfly, with s = sum and d = difference:
  - h = d arithmetic-shifted right by 1 (d treated as signed).
  - b = s − h, then a = d + b, both mod 2^width.
  - Outputs go to positions 2i and 2i+1.
- Level order is L = index_width down to 1. Level L processes pairs i = 0..n/2-1, one per cycle, reading work[i] and work[n/2+i].
- Results go to a scratch bank. On the last pair of a level, work[0..n-1] loads the scratch contents merged with that cycle's pair. Positions at or above n are untouched.
- Counters:
  - `lvl_n`: current group size, starting at 2 and doubling each level.
  - `pair`: pair index within the level.
  - Total RUN cycles = index−1 (7 by default).
- FSM states and transitions:
  - IDLE: on `start`, load work from `indata`, set `lvl_n` = 2 and `pair` = 0, go to RUN.
  - RUN: one pair per cycle. On the last pair of the last level (n = index), go to DONE.
  - DONE: drive `over` = 1 for one cycle, then go to IDLE.
- `start` is ignored in RUN and DONE; no queuing.
- Reset mid-operation aborts: work, scratch and counters go to 0, state goes to IDLE, `over` and `busy` go to 0.

## Timing
- Reset values: `outdata` all 0, `busy` 0, `over` 0, state IDLE.
- Edge E0: `start` is accepted in IDLE and `busy` rises after E0.
- Edges E1..E(index−1): butterflies execute.
- After E(index−1): state is DONE, `over` = 1, `outdata` is final. This is 7 cycles after the accepting edge by default.
- After E(index): state is IDLE, `over` = 0, `busy` = 0. `outdata` holds.
- Back-to-back: `start` held high is re-accepted on the first edge in IDLE. Throughput is one vector per index+1 cycles.
- `outdata` changes during RUN and is valid only while `over` = 1 or afterwards in IDLE.

## Structure
- Package `ht_pkg`:
  - `iht_state_t` enum {IDLE, RUN, DONE}.
  - Shared `index`/`width`/`index_width` defaults.
  - A `ht_shr1` arithmetic-shift helper function, shared with the forward side.
- Sub-module `iht_bfly`: purely combinational, (s, d) → (a, b), parameterised by `width`.
- The top module holds the FSM, counters, work and scratch banks. Target size is about 200 lines.

## Test plan
- Reset mid-RUN: assert `rst` 3 cycles after `start` → outputs immediately 0, IDLE. A new `start` then completes normally.
- Ramp: `indata` = [04,FC,FE,FE,FF,FF,FF,FF] → `outdata` = [01..08], with `over` exactly 7 cycles after acceptance and high for one cycle.
- DC: [10,00,00,00,00,00,00,00] → all 10. All zeros → all 00.
- Wrap/sign: [00,80,00,00,00,00,00,00] → [C0,C0,C0,C0,40,40,40,40].
- Busy ignore: pulse `start` with a different vector during RUN and DONE → result unchanged, no extra `over`. `start` held high continuously → one `over` every 9 cycles.
- Round trip: 1000 random vectors through forward `ht` then `iht` → exact match with the original input.

Source files
------------

// File: rtl/ht_pkg.sv
// Shared definitions for the forward/inverse integer Haar (S-transform) pipelines.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ht_pkg;

  localparam int HT_INDEX       = 8;  // vector length (power of two, >= 2)
  localparam int HT_WIDTH       = 8;  // element width, arithmetic mod 2^width
  localparam int HT_INDEX_WIDTH = 3;  // log2(HT_INDEX) == number of levels

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } iht_state_t;

  // Arithmetic shift right by one of a two's-complement difference term.
  function automatic logic [HT_WIDTH-1:0] ht_shr1(input logic [HT_WIDTH-1:0] x);
    return {x[HT_WIDTH-1], x[HT_WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/iht_if.sv
// Request/result bundle for the inverse Haar engine.
// Latency: n/a (wiring only).
// Backpressure: none; start is only sampled while the engine is idle.
// Signals: start/indata (request), outdata/busy/over (result and status).
interface iht_if
  import ht_pkg::*;
#(
  parameter int index = HT_INDEX,
  parameter int width = HT_WIDTH
);

  logic             start;
  logic [width-1:0] indata  [0:index-1];
  logic [width-1:0] outdata [0:index-1];
  logic             busy;
  logic             over;

  // Requester side (testbench / upstream decoder).
  modport master (
    output start,
    output indata,
    input  outdata,
    input  busy,
    input  over
  );

  // Engine side.
  modport slave (
    input  start,
    input  indata,
    output outdata,
    output busy,
    output over
  );

endinterface

// File: rtl/iht_bfly.sv
// Inverse S-transform butterfly: (sum s, difference d) -> samples (a, b).
// Latency: purely combinational.
// Backpressure: none.
// Ports: s_i, d_i in; a_o (even position), b_o (odd position) out.
module iht_bfly
  import ht_pkg::*;
#(
  parameter int width = HT_WIDTH
) (
  input  logic [width-1:0] s_i,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] a_o,
  output logic [width-1:0] b_o
);

  logic [width-1:0] h;

  // Reuse the shared helper when the width matches the package default,
  // otherwise fall back to the same sign-extending shift at this width.
  generate
    if (width == HT_WIDTH) begin : g_pkg_shr
      assign h = ht_shr1(d_i);
    end else begin : g_local_shr
      assign h = {d_i[width-1], d_i[width-1:1]};
    end
  endgenerate

  assign b_o = s_i - h;
  assign a_o = d_i + b_o;

endmodule

// File: rtl/iht.sv
// Inverse three-level integer Haar: iterative single-butterfly reconstruction.
// Latency: over pulses index-1 cycles after the accepting edge; next start accepted index+1 cycles apart.
// Backpressure: none; start is ignored while busy (RUN/DONE), no queuing.
// Ports: clk, rst (async, active-high); bus (iht_if.slave: start, indata, outdata, busy, over).
module iht
  import ht_pkg::*;
#(
  parameter int index       = HT_INDEX,
  parameter int width       = HT_WIDTH,
  parameter int index_width = HT_INDEX_WIDTH
) (
  input logic   clk,
  input logic   rst,
  iht_if.slave  bus
);

  localparam int CW = index_width + 1;  // holds lvl_n up to index
  localparam logic [CW-1:0]          N_FIRST = CW'(2);
  localparam logic [CW-1:0]          N_LAST  = CW'(index);
  localparam logic [index_width-1:0] ONE     = index_width'(1);

  iht_state_t             state_q;
  logic [CW-1:0]          lvl_n_q;  // current group size n
  logic [index_width-1:0] pair_q;   // pair index within the level
  logic                   busy_q;
  logic                   over_q;

  logic [width-1:0] work_q    [0:index-1];
  logic [width-1:0] scratch_q [0:index-1];
  logic [width-1:0] work_d    [0:index-1];
  logic [width-1:0] scratch_d [0:index-1];

  logic [index_width-1:0] half;
  logic [index_width-1:0] d_sel;
  logic                   last_pair;
  logic                   last_level;
  logic [width-1:0]       bf_s, bf_d, bf_a, bf_b;

  // Sums live at 0..n/2-1, differences at n/2..n-1 of the current group.
  assign half       = lvl_n_q[CW-1:1];
  assign d_sel      = half + pair_q;
  assign last_pair  = (pair_q == half - ONE);
  assign last_level = (lvl_n_q == N_LAST);

  assign bf_s = work_q[pair_q];
  assign bf_d = work_q[d_sel];

  iht_bfly #(.width(width)) u_bfly (
    .s_i (bf_s),
    .d_i (bf_d),
    .a_o (bf_a),
    .b_o (bf_b)
  );

  // The butterfly writes 2i/2i+1, which overlap still-unread difference
  // slots of work, so results collect in scratch. The final pair of a level
  // is merged combinationally so work[0..n-1] can be replaced in one edge.
  always_comb begin
    for (int k = 0; k < index; k++) begin
      scratch_d[k] = scratch_q[k];
      work_d[k]    = work_q[k];
      if (k == 2 * int'(pair_q)) begin
        scratch_d[k] = bf_a;
      end else if (k == 2 * int'(pair_q) + 1) begin
        scratch_d[k] = bf_b;
      end
      if (k < int'(lvl_n_q)) begin
        work_d[k] = scratch_d[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lvl_n_q <= '0;
      pair_q  <= '0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      for (int k = 0; k < index; k++) begin
        work_q[k]    <= '0;
        scratch_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          over_q <= 1'b0;
          if (bus.start) begin
            work_q  <= bus.indata;
            lvl_n_q <= N_FIRST;
            pair_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          scratch_q <= scratch_d;
          if (last_pair) begin
            work_q <= work_d;
            pair_q <= '0;
            if (last_level) begin
              over_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              lvl_n_q <= lvl_n_q << 1;
            end
          end else begin
            pair_q <= pair_q + ONE;
          end
        end
        DONE: begin
          over_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          over_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.outdata = work_q;
  assign bus.busy    = busy_q;
  assign bus.over    = over_q;

endmodule
